// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate D-cache; hit = 0 stall cycles, miss = controller latency + 2.
// Backpressure: cpu_stall holds the core; mem_req and all mem_* outputs stay stable until mem_read_ready.
module dcache_wb #(
    parameter int NUM_LINES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic         cpu_byte,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_stall,
    output logic         mem_req,
    output logic         mem_req_write,
    output logic [25:0]  mem_read_addr,
    output logic [25:0]  mem_write_addr,
    output logic [127:0] mem_write_data,
    input  logic [127:0] mem_read_data,
    input  logic         mem_read_ready,
    input  logic         mem_write_ack
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - 4 - IDX_W;

    typedef enum logic [1:0] {IDLE, MISS_WAIT, REPLAY} state_t;

    state_t               state;
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [127:0]         data_arr [NUM_LINES];
    logic [31:0]          rdata_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             do_access;
    logic             do_miss;
    logic             do_fill;
    logic [127:0]     cur_line;
    logic [127:0]     line_wr;
    logic [31:0]      ld_word;
    logic [31:0]      ld_val;
    logic             unused_ack;

    // The write ack carries no state: the victim rides along with the refill.
    assign unused_ack = mem_write_ack;

    assign idx       = cpu_addr[4 +: IDX_W];
    assign tag       = cpu_addr[31 -: TAG_W];
    assign hit       = valid[idx] && (tag_arr[idx] == tag);
    assign do_miss   = (state == IDLE) && cpu_req && !hit;
    assign do_access = ((state == IDLE) && cpu_req && hit) || (state == REPLAY);
    assign do_fill   = (state == MISS_WAIT) && mem_read_ready;

    assign cur_line = data_arr[idx];
    assign ld_word  = cur_line[{cpu_addr[3:2], 5'b0} +: 32];

    always_comb begin
        ld_val  = cpu_byte ? {24'b0, ld_word[{cpu_addr[1:0], 3'b0} +: 8]} : ld_word;
        line_wr = cur_line;
        if (cpu_byte) begin
            line_wr[{cpu_addr[3:0], 3'b0} +: 8] = cpu_wdata[7:0];
        end else begin
            line_wr[{cpu_addr[3:2], 5'b0} +: 32] = cpu_wdata;
        end
    end

    assign cpu_stall = do_miss || (state == MISS_WAIT);
    assign cpu_rdata = (do_access && !cpu_we) ? ld_val : rdata_q;

    // Line payload and tags need no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            data_arr[idx] <= mem_read_data;
            tag_arr[idx]  <= tag;
        end else if (do_access && cpu_we) begin
            data_arr[idx] <= line_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            valid          <= '0;
            dirty          <= '0;
            rdata_q        <= '0;
            mem_req        <= 1'b0;
            mem_req_write  <= 1'b0;
            mem_read_addr  <= '0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_miss) begin
                        state          <= MISS_WAIT;
                        mem_req        <= 1'b1;
                        mem_req_write  <= valid[idx] && dirty[idx];
                        mem_read_addr  <= cpu_addr[29:4];
                        mem_write_addr <= 26'({tag_arr[idx], idx});
                        mem_write_data <= cur_line;
                    end
                end
                MISS_WAIT: begin
                    if (mem_read_ready) begin
                        state         <= REPLAY;
                        mem_req       <= 1'b0;
                        mem_req_write <= 1'b0;
                        valid[idx]    <= 1'b1;
                        dirty[idx]    <= 1'b0;
                    end
                end
                REPLAY:  state <= IDLE;
                default: state <= IDLE;
            endcase
            // Hits and the replay share one path; a replayed store re-dirties the fresh line.
            if (do_access) begin
                if (cpu_we) begin
                    dirty[idx] <= 1'b1;
                end else begin
                    rdata_q <= ld_val;
                end
            end
        end
    end
endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline's memory stage and the memory controller's D-side port.
- Serves byte and word loads and stores from the core.
- On a miss it stalls the core and issues one memory transaction, which combines the dirty-victim writeback and the line refill.
- Then it installs the line and completes the access.

Parameters:
- NUM_LINES, 4, number of cache lines (power of 2, >=2); IDX_W = log2(NUM_LINES).
- LINE_BITS, 128, line width; 16 bytes, fixed by the memory interface.
- TAG_W, 32-4-IDX_W, tag width taken from cpu_addr[31:4+IDX_W].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset, sampled on rising clk.
- cpu_req  in  1  access valid this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_byte  in  1  1 = byte access, 0 = word access (word requires addr[1:0]==0).
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data; byte stores use [7:0].
- cpu_rdata  out  32  load data; a byte load is zero-extended.
- cpu_stall  out  1  access not complete; core holds all cpu_* inputs stable.
- mem_req  out  1  to controller reqD_cache.
- mem_req_write  out  1  to controller reqD_cache_write; victim writeback accompanies the refill.
- mem_read_addr  out  26  refill line address, cpu_addr[29:4].
- mem_write_addr  out  26  victim line address, {victim_tag, idx}[25:0].
- mem_write_data  out  128  victim line data.
- mem_read_data  in  128  refill line from controller.
- mem_read_ready  in  1  one-cycle pulse; mem_read_data valid in the same cycle.
- mem_write_ack  in  1  one-cycle pulse when the controller latches the victim.

Behaviour:
- Storage: per line valid, dirty, tag[TAG_W], data[128].
  - Index = cpu_addr[4+IDX_W-1:4]. Word select = addr[3:2]. Byte select = addr[1:0]. Word 0 = data[31:0].
- Reset (reset==0 at clk edge):
  - All valid=0, dirty=0, state=IDLE.
  - cpu_stall=0, cpu_rdata=0, mem_req=0, mem_req_write=0, mem_read_addr=0, mem_write_addr=0, mem_write_data=0.
  - Reset mid-transaction abandons it. Any later mem_read_ready pulse is ignored while in IDLE.
- Hit (IDLE, cpu_req, valid && tag match):
  - Combinational lookup, zero-stall; cpu_stall=0 that cycle.
  - Load: cpu_rdata is valid in the same cycle.
  - Store: the selected byte or word is written at the clock edge and dirty is set.
- Miss (IDLE, cpu_req, not hit):
  - cpu_stall=1 combinationally in the same cycle.
  - Next edge: go to MISS_WAIT and register the address outputs.
  - mem_req_write = valid && dirty of the victim. mem_write_data and mem_write_addr are taken from the victim.
- MISS_WAIT:
  - Hold mem_req=1 and all mem_* outputs stable until mem_read_ready==1.
  - mem_write_ack is informational only. It never changes state, and mem_req_write stays high until the refill returns.
  - On the ready cycle: write mem_read_data into the line, valid=1, tag=new tag, dirty=0.
  - Next state: REPLAY. mem_req and mem_req_write deassert at that edge, so the controller sees req low in its ready cycle and afterwards.
- REPLAY:
  - Re-executes the held access as a hit, with the same actions as a hit.
  - cpu_stall=0 this cycle; return to IDLE.
  - Miss latency visible to the core = controller latency + 2 cycles.
- cpu_req=0: no state change; cpu_rdata holds its last value.
- A load returns data from the array as it stands before that edge's writes. A replayed store sets dirty after the refill clears it.
- Non-cacheable or unaligned word access: no exception. addr[1:0] is ignored for words.

Test Plan:
1. Reset, then load word 0x0000_0040 -> cpu_stall=1, mem_req=1, mem_req_write=0, mem_read_addr=0x000004. Return line with word0=0xDEADBEEF -> stall drops 1 cycle after ready, cpu_rdata=0xDEADBEEF.
2. Same line: store byte 0xA5 to 0x42, then load word 0x40 -> no stall on either; cpu_rdata=0xDEA5BEEF; line dirty.
3. Load 0x0000_0080 (same index when NUM_LINES=4, different tag) -> mem_req_write=1, mem_write_addr=0x000004, mem_write_data[31:0]=0xDEA5BEEF, mem_read_addr=0x000008. mem_req_write stays high through the write-ack pulse until ready.
4. Store-miss word 0x1234_5678 to clean line 0x90 -> refill, then REPLAY writes the word; line dirty. A following load of 0x90 returns 0x12345678 with no stall.
5. Drop reset low during MISS_WAIT -> next edge mem_req=0, cpu_stall=0, all lines invalid. A late mem_read_ready is ignored and the next access to 0x40 misses.
6. Controller ready delayed 20 cycles -> mem_* outputs are stable for every cycle of MISS_WAIT and cpu_stall stays high throughout.
